// File: rtl/codec_i2c_config_sequencer_if.sv
// Control and status bundle for the WM8731 boot-time configuration sequencer.
//   start     : 1-cycle launch pulse toward the sequencer
//   i2c_sclk  : config-bus clock, push-pull
//   busy      : sequence in progress
//   done      : all ROM entries written and ACKed
//   ack_err   : retries exhausted on one entry
//   reg_index : ROM entry currently being written
// The open-drain data line stays a plain inout on the sequencer so it resolves like a pin.
interface codec_i2c_config_sequencer_if;
   logic       start;
   logic       i2c_sclk;
   logic       busy;
   logic       done;
   logic       ack_err;
   logic [3:0] reg_index;

   modport master (
      input  start,
      output i2c_sclk,
      output busy,
      output done,
      output ack_err,
      output reg_index
   );

   modport slave (
      output start,
      input  i2c_sclk,
      input  busy,
      input  done,
      input  ack_err,
      input  reg_index
   );
endinterface

// File: rtl/codec_i2c_config_sequencer.sv
// Boot-time configuration controller for the WM8731 codec. Walks an 11-entry register ROM and
// writes each entry as {addr byte, reg/data[8], data[7:0]} over the 2-wire config bus. NACKed
// writes are retried up to MAX_RETRY times, then the sequence stops with ack_err.
// Ports:
//   clk_clk       : system clock
//   reset_reset_n : asynchronous active-low reset
//   cfg           : start / i2c_sclk / busy / done / ack_err / reg_index (master modport)
//   i2c_sdat      : open-drain data line, driven 0 or released, never 1
module codec_i2c_config_sequencer #(
   parameter int unsigned CLK_HZ     = 50_000_000,
   parameter int unsigned I2C_HZ     = 100_000,
   parameter logic [6:0]  DEV_ADDR   = 7'h1A,
   parameter int unsigned MAX_RETRY  = 3,
   parameter int unsigned AUTO_START = 1
) (
   input  logic                                clk_clk,
   input  logic                                reset_reset_n,
   codec_i2c_config_sequencer_if.master        cfg,
   inout  wire                                 i2c_sdat
);

   localparam int unsigned DIV     = CLK_HZ / (4 * I2C_HZ);
   localparam int unsigned CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);
   localparam logic [7:0]       RETRY_MAX = 8'(MAX_RETRY);

   typedef enum logic [2:0] {StIdle, StStart, StBit, StStop, StGap, StDone, StErr} state_e;

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [1:0]       q_q;        // quarter within the current bus phase
   logic [3:0]       bit_q;      // 0..7 data, 8 = ACK slot
   logic [1:0]       byte_q;
   logic [23:0]      shreg_q;
   logic             nack_q;
   logic [7:0]       retry_q;
   logic [3:0]       reg_index_q;
   logic             busy_q, done_q, ack_err_q;
   logic             sclk_q, sda_low_q;
   logic             auto_q;
   logic [1:0]       sda_sync_q;
   logic             tick;

   function automatic logic [15:0] rom_entry(input logic [3:0] idx);
      case (idx)
         4'd0:    rom_entry = 16'h1E00;  // R15 reset
         4'd1:    rom_entry = 16'h0017;  // R0 left line in
         4'd2:    rom_entry = 16'h0217;  // R1 right line in
         4'd3:    rom_entry = 16'h0479;  // R2 left headphone
         4'd4:    rom_entry = 16'h0679;  // R3 right headphone
         4'd5:    rom_entry = 16'h0812;  // R4 analogue path
         4'd6:    rom_entry = 16'h0A00;  // R5 digital path
         4'd7:    rom_entry = 16'h0C00;  // R6 power down
         4'd8:    rom_entry = 16'h0E42;  // R7 master, I2S
         4'd9:    rom_entry = 16'h1000;  // R8 sampling
         4'd10:   rom_entry = 16'h1201;  // R9 active
         default: rom_entry = 16'h0000;
      endcase
   endfunction

   function automatic logic [23:0] frame(input logic [3:0] idx);
      frame = {DEV_ADDR, 1'b0, rom_entry(idx)};
   endfunction

   assign tick = busy_q && (cnt_q == CNT_MAX);

   assign cfg.i2c_sclk  = sclk_q;
   assign cfg.busy      = busy_q;
   assign cfg.done      = done_q;
   assign cfg.ack_err   = ack_err_q;
   assign cfg.reg_index = reg_index_q;
   assign i2c_sdat      = sda_low_q ? 1'b0 : 1'bz;

   // SDA is only sampled at the end of an SCL-high quarter, long after it settled.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) sda_sync_q <= 2'b11;
      else                sda_sync_q <= {sda_sync_q[0], i2c_sdat};
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         q_q         <= '0;
         bit_q       <= '0;
         byte_q      <= '0;
         shreg_q     <= '0;
         nack_q      <= 1'b0;
         retry_q     <= '0;
         reg_index_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         ack_err_q   <= 1'b0;
         sclk_q      <= 1'b1;
         sda_low_q   <= 1'b0;
         auto_q      <= (AUTO_START != 0);
      end else begin
         if (busy_q && !tick) cnt_q <= cnt_q + CNT_W'(1);
         else                 cnt_q <= '0;

         case (state_q)
            StIdle: begin
               if (cfg.start || auto_q) begin
                  auto_q      <= 1'b0;
                  busy_q      <= 1'b1;
                  done_q      <= 1'b0;
                  ack_err_q   <= 1'b0;
                  reg_index_q <= '0;
                  retry_q     <= '0;
                  nack_q      <= 1'b0;
                  shreg_q     <= frame(4'd0);
                  q_q         <= '0;
                  sclk_q      <= 1'b1;
                  sda_low_q   <= 1'b0;
                  state_q     <= StStart;
               end
            end

            StStart: if (tick) begin
               q_q <= q_q + 2'd1;
               unique case (q_q)
                  2'd0: begin sclk_q <= 1'b1; sda_low_q <= 1'b1; end
                  2'd1: begin sclk_q <= 1'b0; sda_low_q <= 1'b1; end
                  2'd2: begin sclk_q <= 1'b0; sda_low_q <= 1'b1; end
                  2'd3: begin
                     state_q   <= StBit;
                     bit_q     <= '0;
                     byte_q    <= '0;
                     sclk_q    <= 1'b0;
                     sda_low_q <= ~shreg_q[23];
                  end
               endcase
            end

            StBit: if (tick) begin
               q_q <= q_q + 2'd1;
               unique case (q_q)
                  2'd0: sclk_q <= 1'b1;
                  2'd1: sclk_q <= 1'b1;
                  2'd2: begin
                     sclk_q <= 1'b0;
                     if (bit_q == 4'd8) nack_q <= sda_sync_q[1];
                  end
                  2'd3: begin
                     if (bit_q == 4'd8) begin
                        // A NACK abandons the rest of the frame.
                        if (nack_q || byte_q == 2'd2) begin
                           state_q   <= StStop;
                           sda_low_q <= 1'b1;
                        end else begin
                           byte_q    <= byte_q + 2'd1;
                           bit_q     <= '0;
                           sda_low_q <= ~shreg_q[23];
                        end
                     end else begin
                        shreg_q   <= {shreg_q[22:0], 1'b0};
                        bit_q     <= bit_q + 4'd1;
                        // Release SDA for the ACK slot after the 8th data bit.
                        sda_low_q <= (bit_q == 4'd7) ? 1'b0 : ~shreg_q[22];
                     end
                  end
               endcase
            end

            StStop: if (tick) begin
               q_q <= q_q + 2'd1;
               unique case (q_q)
                  2'd0: begin sclk_q <= 1'b1; sda_low_q <= 1'b1; end
                  2'd1: begin sclk_q <= 1'b1; sda_low_q <= 1'b0; end
                  2'd2: begin sclk_q <= 1'b1; sda_low_q <= 1'b0; end
                  2'd3: state_q <= StGap;
               endcase
            end

            StGap: if (tick) begin
               q_q <= q_q + 2'd1;
               if (q_q == 2'd3) begin
                  if (nack_q) begin
                     if (retry_q < RETRY_MAX) begin
                        retry_q <= retry_q + 8'd1;
                        nack_q  <= 1'b0;
                        shreg_q <= frame(reg_index_q);
                        state_q <= StStart;
                     end else begin
                        busy_q    <= 1'b0;
                        ack_err_q <= 1'b1;
                        state_q   <= StErr;
                     end
                  end else if (reg_index_q == 4'd10) begin
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= StDone;
                  end else begin
                     reg_index_q <= reg_index_q + 4'd1;
                     retry_q     <= '0;
                     shreg_q     <= frame(reg_index_q + 4'd1);
                     state_q     <= StStart;
                  end
               end
            end

            // One-cycle terminal states; a start seen here is dropped.
            StDone:  state_q <= StIdle;
            StErr:   state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule
